// File: rtl/prbs15_byte_gen_pkg.sv
// Shared constants, state encoding and helpers for the PRBS-15 byte generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prbs15_byte_gen_pkg;

  localparam int BYTE_W = 8;
  localparam int LFSR_W = 15;

  // Fibonacci taps for x^15 + x^14 + 1
  localparam int TAP_HI = 14;
  localparam int TAP_LO = 13;

  localparam logic [31:0]       SEQUENCE_DEF = 32'hCCDDEEFF;
  localparam logic [LFSR_W-1:0] SEED_DEF     = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PATTERN = 2'd1,
    PRBS    = 2'd2
  } state_t;

  // Pattern byte at position idx, most significant byte first.
  function automatic logic [BYTE_W-1:0] pattern_byte(input logic [31:0] seq,
                                                     input logic [1:0]  idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = seq[31:24];
      2'd1:    b = seq[23:16];
      2'd2:    b = seq[15:8];
      default: b = seq[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prbs15_byte_gen_step8.sv
// Advances the PRBS-15 Fibonacci LFSR by 8 steps and collects the 8 feedback bits.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to store the advanced state.
//
// Ports:
//   lfsr     - current 15-bit LFSR state
//   byte_val - the 8 generated bits, first generated bit in [7]
//   lfsr_adv - LFSR state after the 8 steps
module prbs15_step8
  import prbs15_byte_gen_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr,
  output logic [BYTE_W-1:0] byte_val,
  output logic [LFSR_W-1:0] lfsr_adv
);

  logic [LFSR_W-1:0] s;
  logic              fb;

  always_comb begin
    s        = lfsr;
    fb       = 1'b0;
    byte_val = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      fb                    = s[TAP_HI] ^ s[TAP_LO];
      byte_val[BYTE_W-1-i]  = fb;
      s                     = {s[LFSR_W-2:0], fb};
    end
    lfsr_adv = s;
  end

endmodule

// File: rtl/prbs15_byte_gen.sv
// Byte source: framing pattern repeated n times (MSB first), then a PRBS-15 byte stream.
// Latency: first byte registered on the start edge; one byte per clock, no gaps.
// Backpressure: none; the stream runs while en is high and stops on the edge en is low.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   en          - run request, level-sensitive
//   n           - pattern repetitions, sampled on the start edge only (0 means 4)
//   data_out    - current byte (registered)
//   valid       - data_out carries a stream byte
//   prbs_active - data_out is a PRBS byte rather than a pattern byte
module prbs15_byte_gen
  import prbs15_byte_gen_pkg::*;
#(
  parameter logic [31:0]       SEQUENCE = SEQUENCE_DEF,
  parameter logic [LFSR_W-1:0] SEED     = SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        n,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid,
  output logic              prbs_active
);

  state_t            state;
  logic [1:0]        byte_idx;   // position of the byte currently on data_out
  logic [2:0]        rep_cnt;    // completed repetitions
  logic [2:0]        rep_tgt;    // 3 bits so that a target of 4 fits
  logic [LFSR_W-1:0] lfsr;

  logic [BYTE_W-1:0] prbs_byte;
  logic [LFSR_W-1:0] lfsr_adv;

  prbs15_step8 u_step8 (
    .lfsr     (lfsr),
    .byte_val (prbs_byte),
    .lfsr_adv (lfsr_adv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_idx    <= 2'd0;
      rep_cnt     <= 3'd0;
      rep_tgt     <= 3'd0;
      lfsr        <= SEED;
      data_out    <= '0;
      valid       <= 1'b0;
      prbs_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            rep_tgt     <= (n == 2'd0) ? 3'd4 : {1'b0, n};
            lfsr        <= SEED;
            byte_idx    <= 2'd0;
            rep_cnt     <= 3'd0;
            data_out    <= pattern_byte(SEQUENCE, 2'd0);
            valid       <= 1'b1;
            prbs_active <= 1'b0;
            state       <= PATTERN;
          end
        end

        PATTERN: begin
          if (!en) begin
            state       <= IDLE;
            data_out    <= '0;
            valid       <= 1'b0;
            prbs_active <= 1'b0;
          end else if (byte_idx == 2'd3) begin
            // Last byte of a repetition is on the wire: either wrap or hand over.
            rep_cnt  <= rep_cnt + 3'd1;
            byte_idx <= 2'd0;
            if (rep_cnt + 3'd1 == rep_tgt) begin
              // The LFSR still holds SEED here, so the first PRBS byte is
              // generated from the freshly loaded state.
              data_out    <= prbs_byte;
              lfsr        <= lfsr_adv;
              prbs_active <= 1'b1;
              state       <= PRBS;
            end else begin
              data_out <= pattern_byte(SEQUENCE, 2'd0);
            end
          end else begin
            byte_idx <= byte_idx + 2'd1;
            data_out <= pattern_byte(SEQUENCE, byte_idx + 2'd1);
          end
        end

        PRBS: begin
          if (!en) begin
            state       <= IDLE;
            data_out    <= '0;
            valid       <= 1'b0;
            prbs_active <= 1'b0;
          end else begin
            data_out <= prbs_byte;
            lfsr     <= lfsr_adv;
          end
        end

        default: begin
          state       <= IDLE;
          data_out    <= '0;
          valid       <= 1'b0;
          prbs_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs15_byte_gen.sv
// Directed bench for prbs15_byte_gen: pattern framing, repetition count, PRBS stream,
// stop/restart, asynchronous reset and a downstream framing detector.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_prbs15_byte_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] n;
  logic [7:0] data_out;
  logic       valid;
  logic       prbs_active;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  pat [4] = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};
  logic [14:0] ref_lfsr;

  prbs15_byte_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .n           (n),
    .data_out    (data_out),
    .valid       (valid),
    .prbs_active (prbs_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bit-serial reference: one LFSR step per loop, first feedback bit into [7].
  task automatic ref_next_byte(output logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb       = ref_lfsr[14] ^ ref_lfsr[13];
      b[7-i]   = fb;
      ref_lfsr = {ref_lfsr[13:0], fb};
    end
  endtask

  // Leaves rst released at a falling edge with en low.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    n   = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    en = 1'b1;
    #1;
    tests_run++;
    if ({valid, prbs_active, data_out} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_async: got v=%b p=%b d=%h want v=0 p=0 d=00", valid, prbs_active, data_out);
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if ({valid, prbs_active, data_out} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: got v=%b p=%b d=%h want v=0 p=0 d=00", valid, prbs_active, data_out);
    end
    rst = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_pattern_n2();
    apply_reset();
    en = 1'b1;
    n  = 2'd2;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tests_run++;
      if ({valid, prbs_active, data_out} !== {1'b1, 1'b0, pat[(c-1)%4]}) begin
        tests_failed++;
        $display("FAIL pattern_n2 cycle %0d: got v=%b p=%b d=%h want v=1 p=0 d=%h",
                 c, valid, prbs_active, data_out, pat[(c-1)%4]);
      end
    end
    @(negedge clk);
    tests_run++;
    if ({valid, prbs_active, data_out} !== {1'b1, 1'b1, 8'h00}) begin
      tests_failed++;
      $display("FAIL first_prbs: got v=%b p=%b d=%h want v=1 p=1 d=00", valid, prbs_active, data_out);
    end
    @(negedge clk);
    tests_run++;
    if ({valid, prbs_active, data_out} !== {1'b1, 1'b1, 8'h02}) begin
      tests_failed++;
      $display("FAIL second_prbs: got v=%b p=%b d=%h want v=1 p=1 d=02", valid, prbs_active, data_out);
    end
    en = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({valid, prbs_active, data_out} !== 10'b0) begin
      tests_failed++;
      $display("FAIL stop_prbs: got v=%b p=%b d=%h want v=0 p=0 d=00", valid, prbs_active, data_out);
    end
  endtask

  task automatic test_n0();
    apply_reset();
    en = 1'b1;
    n  = 2'd0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 3) n = 2'd1;  // must be ignored after the start edge
      tests_run++;
      if ({valid, prbs_active, data_out} !== {1'b1, 1'b0, pat[(c-1)%4]}) begin
        tests_failed++;
        $display("FAIL pattern_n0 cycle %0d: got v=%b p=%b d=%h want v=1 p=0 d=%h",
                 c, valid, prbs_active, data_out, pat[(c-1)%4]);
      end
    end
    @(negedge clk);
    tests_run++;
    if ({valid, prbs_active, data_out} !== {1'b1, 1'b1, 8'h00}) begin
      tests_failed++;
      $display("FAIL n0_first_prbs: got v=%b p=%b d=%h want v=1 p=1 d=00", valid, prbs_active, data_out);
    end
    en = 1'b0;
  endtask

  task automatic test_prbs_period();
    logic [7:0] first8 [8];
    logic [7:0] b;
    int         bad_cnt;
    int         bad_idx;
    logic [7:0] bad_got;
    logic [7:0] bad_exp;
    apply_reset();
    en = 1'b1;
    n  = 2'd1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests_run++;
      if ({valid, prbs_active, data_out} !== {1'b1, 1'b0, pat[c-1]}) begin
        tests_failed++;
        $display("FAIL pattern_n1 cycle %0d: got v=%b p=%b d=%h want v=1 p=0 d=%h",
                 c, valid, prbs_active, data_out, pat[c-1]);
      end
    end
    ref_lfsr = 15'h7FFF;
    bad_cnt  = 0;
    bad_idx  = -1;
    bad_got  = 8'h00;
    bad_exp  = 8'h00;
    for (int k = 0; k < 32767 + 8; k++) begin
      @(negedge clk);
      ref_next_byte(b);
      if (k < 8) first8[k] = b;
      if ({valid, prbs_active, data_out} !== {1'b1, 1'b1, b}) begin
        if (bad_cnt == 0) begin
          bad_idx = k;
          bad_got = data_out;
          bad_exp = b;
        end
        bad_cnt++;
      end
      if (k >= 32767) begin
        tests_run++;
        if (data_out !== first8[k-32767]) begin
          tests_failed++;
          $display("FAIL prbs_period k=%0d: got %h want %h", k - 32767, data_out, first8[k-32767]);
        end
      end
    end
    tests_run++;
    if (bad_cnt !== 0) begin
      tests_failed++;
      $display("FAIL prbs_stream: %0d bad bytes, first at %0d got %h want %h (want 0 bad)",
               bad_cnt, bad_idx, bad_got, bad_exp);
    end
    en = 1'b0;
  endtask

  task automatic test_stop_restart();
    apply_reset();
    en = 1'b1;
    n  = 2'd2;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests_run++;
      if ({valid, data_out} !== {1'b1, pat[c-1]}) begin
        tests_failed++;
        $display("FAIL stop_pre cycle %0d: got v=%b d=%h want v=1 d=%h", c, valid, data_out, pat[c-1]);
      end
    end
    en = 1'b0;  // dropped while EE is on the wire
    @(negedge clk);
    tests_run++;
    if ({valid, prbs_active, data_out} !== 10'b0) begin
      tests_failed++;
      $display("FAIL stop_pattern: got v=%b p=%b d=%h want v=0 p=0 d=00", valid, prbs_active, data_out);
    end
    @(negedge clk);
    tests_run++;
    if ({valid, prbs_active, data_out} !== 10'b0) begin
      tests_failed++;
      $display("FAIL stop_stays_idle: got v=%b p=%b d=%h want v=0 p=0 d=00", valid, prbs_active, data_out);
    end
    en = 1'b1;
    n  = 2'd1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests_run++;
      if ({valid, prbs_active, data_out} !== {1'b1, 1'b0, pat[c-1]}) begin
        tests_failed++;
        $display("FAIL restart cycle %0d: got v=%b p=%b d=%h want v=1 p=0 d=%h",
                 c, valid, prbs_active, data_out, pat[c-1]);
      end
    end
    @(negedge clk);
    tests_run++;
    if ({valid, prbs_active, data_out} !== {1'b1, 1'b1, 8'h00}) begin
      tests_failed++;
      $display("FAIL restart_prbs0: got v=%b p=%b d=%h want v=1 p=1 d=00", valid, prbs_active, data_out);
    end
    @(negedge clk);
    tests_run++;
    if ({valid, prbs_active, data_out} !== {1'b1, 1'b1, 8'h02}) begin
      tests_failed++;
      $display("FAIL restart_prbs1: got v=%b p=%b d=%h want v=1 p=1 d=02", valid, prbs_active, data_out);
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    en = 1'b1;
    n  = 2'd1;
    repeat (7) @(negedge clk);
    tests_run++;
    if ({valid, prbs_active} !== 2'b11) begin
      tests_failed++;
      $display("FAIL arst_pre: got v=%b p=%b want v=1 p=1", valid, prbs_active);
    end
    #2 rst = 1'b1;  // between edges
    #1;
    tests_run++;
    if ({valid, prbs_active, data_out} !== 10'b0) begin
      tests_failed++;
      $display("FAIL arst_clear: got v=%b p=%b d=%h want v=0 p=0 d=00", valid, prbs_active, data_out);
    end
    @(negedge clk);
    rst = 1'b0;  // en still high: next rising edge is the start edge
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests_run++;
      if ({valid, prbs_active, data_out} !== {1'b1, 1'b0, pat[c-1]}) begin
        tests_failed++;
        $display("FAIL arst_restart cycle %0d: got v=%b p=%b d=%h want v=1 p=0 d=%h",
                 c, valid, prbs_active, data_out, pat[c-1]);
      end
    end
    @(negedge clk);
    tests_run++;
    if ({valid, prbs_active, data_out} !== {1'b1, 1'b1, 8'h00}) begin
      tests_failed++;
      $display("FAIL arst_prbs0: got v=%b p=%b d=%h want v=1 p=1 d=00", valid, prbs_active, data_out);
    end
    en = 1'b0;
  endtask

  // Downstream framing detector: flags once three back-to-back framing words are seen.
  task automatic test_detector_n3();
    logic [31:0] sh;
    int          hits;
    logic        flag;
    sh   = 32'h0;
    hits = 0;
    flag = 1'b0;
    apply_reset();
    en = 1'b1;
    n  = 2'd3;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (valid) begin
        sh = {sh[23:0], data_out};
        if (sh == 32'hCCDDEEFF) hits++;
      end
      flag = (hits >= 3);
      if (c == 11) begin
        tests_run++;
        if (flag !== 1'b0) begin
          tests_failed++;
          $display("FAIL detector_early: flag=%b after byte 11, want 0", flag);
        end
      end
      if (c == 12) begin
        tests_run++;
        if (flag !== 1'b1) begin
          tests_failed++;
          $display("FAIL detector_flag: flag=%b hits=%0d after byte 12, want 1", flag, hits);
        end
      end
      if (c == 13) begin
        tests_run++;
        if ({valid, prbs_active, data_out} !== {1'b1, 1'b1, 8'h00}) begin
          tests_failed++;
          $display("FAIL n3_first_prbs: got v=%b p=%b d=%h want v=1 p=1 d=00", valid, prbs_active, data_out);
        end
      end
    end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    n   = 2'd0;
    test_reset();
    test_pattern_n2();
    test_n0();
    test_stop_restart();
    test_async_reset();
    test_detector_n3();
    test_prbs_period();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prbs15_byte_gen.md
# prbs15_byte_gen

- Byte-stream source that sits directly upstream of the byte sequence detector and drives its `data_in` each cycle.
- After `en` is raised, it emits the 4-byte framing pattern `n` times, most significant byte first.
- It then emits a continuous PRBS-15 byte stream until `en` drops.
- Output is registered, one byte per clock.

## Interface
Parameters:
- `SEQUENCE`, 32'hCCDDEEFF: framing pattern; byte order on the wire is [31:24], [23:16], [15:8], [7:0].
- `SEED`, 15'h7FFF: LFSR load value. Must be nonzero; the all-zero value is illegal and is not checked.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: run request. Level-sensitive, sampled on every rising edge.
- `n`, input, 2: pattern repetitions. Sampled only on the start edge; `n==0` means 4.
- `data_out`, output, 8: current byte.
- `valid`, output, 1: `data_out` carries a stream byte.
- `prbs_active`, output, 1: the current byte is a PRBS byte rather than a pattern byte.

## Operation
State machine states are IDLE, PATTERN and PRBS.

Internal registers:
- `byte_idx` (2 bits): byte position within the pattern.
- `rep_cnt` (3 bits): completed pattern repetitions.
- `rep_tgt` (3 bits): latched repetition target.
- `lfsr` (15 bits).

IDLE:
- `valid`=0, `prbs_active`=0, `data_out`=8'h00.
- If `en`=1 on an edge, take that edge as the start edge:
  - latch `rep_tgt` = (`n`==0 ? 4 : `n`);
  - load `lfsr` ← `SEED`;
  - set `byte_idx`=0 and `rep_cnt`=0;
  - on the same edge, register `data_out` ← `SEQUENCE[31:24]` and `valid` ← 1;
  - go to PATTERN.

PATTERN:
- Each edge, `byte_idx` advances and `data_out` ← the next pattern byte.
- When byte index 3 has been output, `rep_cnt` increments and `byte_idx` wraps to 0.
- The edge that follows the final byte of repetition `rep_tgt` registers the first PRBS byte, sets `prbs_active` ← 1 and enters PRBS.

PRBS:
- The LFSR is Fibonacci, polynomial x^15+x^14+1.
- One step is: `fb` = `lfsr[14]`^`lfsr[13]`, then `lfsr` ← {`lfsr[13:0]`, `fb`}.
- One byte = 8 consecutive steps taken within a single cycle.
- The first `fb` generated goes to `data_out[7]` and the last to `data_out[0]`.
- Each edge both registers the byte and stores the 8-step-advanced LFSR state.
- The stream runs indefinitely while `en`=1.

Stop and reset:
- `en`=0 on any edge while in PATTERN or PRBS: go to IDLE. On that edge `valid` ← 0, `prbs_active` ← 0 and `data_out` ← 8'h00.
- The stream does not resume. The next start edge reloads `SEED` and restarts from pattern byte 0 with a freshly sampled `n`.
- `rst` asserted at any time forces IDLE immediately. All outputs and registers go to 0, except `lfsr`, which goes to `SEED`.

Width and arithmetic rules:
- `rep_cnt` and `rep_tgt` are 3 bits so that the target value 4 is representable.
- The `n` input is ignored outside the start edge.

## Timing
- Start latency: the first byte 8'hCC is visible immediately after the start edge, i.e. one cycle after `en` is seen high.
- Throughput: one byte per cycle, with no gaps between the pattern bytes and the first PRBS byte.
- Number of pattern bytes = 4×`rep_tgt`.
- The first PRBS byte appears in cycle 4×`rep_tgt`+1, counting the cycle after the start edge as cycle 1.
- Stop latency: `valid` falls on the edge where `en`=0 is sampled.
- Reset is asynchronous on assertion and is released synchronously to the design. The first start edge is the first edge with `rst`=0 and `en`=1.
- Byte-stream period in PRBS: 32767 bytes. This holds because gcd(8, 32767)=1.

## Structure
Shared package holds:
- the `SEQUENCE` default;
- the `SEED` default;
- the LFSR width (15) and tap positions (14, 13);
- the state enum (IDLE/PATTERN/PRBS);
- the byte width (8).

Sub-module `prbs15_step8`:
- purely combinational;
- takes the 15-bit state;
- returns the 8-bit output byte and the 15-bit state advanced 8 steps.

The top level holds the state machine, counters and output registers.

## Test plan
1. Reset, then `en`=1 with `n`=2 → `data_out` CC,DD,EE,FF,CC,DD,EE,FF on cycles 1–8 with `valid`=1 and `prbs_active`=0. Cycle 9 = 8'h00 with `prbs_active`=1, since the first byte for `SEED`=7FFF is 0x00.
2. `n`=0 → exactly 16 pattern bytes, then PRBS. Changing `n` mid-run has no effect.
3. PRBS run for 32767+8 bytes → byte k+32767 equals byte k for k=0..7, checked against a bit-serial reference model.
4. Drop `en` during pattern byte EE → `valid`=0 and `data_out`=00 on the next cycle. A restart begins at CC with the LFSR reloaded, so the first PRBS byte is again 0x00.
5. Assert `rst` asynchronously mid-PRBS, between clock edges → outputs clear immediately. After release with `en`=1, the stream restarts at CC.
6. Connect the block to the sequence detector with `n`=3 → the detector's flag asserts after the 12th pattern byte.
